// File: rtl/mem_copy_engine_if.sv
// Bundle for the block-copy engine. It groups the control side (Start, Abort, parameters,
// Busy, Done, WordsDone) with the data-RAM side (DataAddress, ReadMem, WriteMem, WriteData,
// ReadData).
//   slave  : the copy engine itself
//   master : the host plus RAM that surrounds the engine
interface mem_copy_engine_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 16
);
  logic              Start;
  logic              Abort;
  logic [ADDR_W-1:0] SrcAddr;
  logic [ADDR_W-1:0] DstAddr;
  logic [LEN_W-1:0]  Length;
  logic              Busy;
  logic              Done;
  logic [LEN_W-1:0]  WordsDone;
  logic [ADDR_W-1:0] DataAddress;
  logic              ReadMem;
  logic              WriteMem;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;

  modport slave (
    input  Start, Abort, SrcAddr, DstAddr, Length, ReadData,
    output Busy, Done, WordsDone, DataAddress, ReadMem, WriteMem, WriteData
  );

  modport master (
    output Start, Abort, SrcAddr, DstAddr, Length, ReadData,
    input  Busy, Done, WordsDone, DataAddress, ReadMem, WriteMem, WriteData
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Block-copy initiator for the 16-bit data RAM. On an accepted Start it copies Length words,
// in ascending order, from SrcAddr to DstAddr. Each word takes two cycles: one READ and one
// WRITE. The RAM read is asynchronous and the RAM write happens on posedge clk.
// Ports:
//   clk   : single clock
//   reset : asynchronous, active-high; clears all state
//   bus   : mem_copy_engine_if.slave, which carries the control inputs, the status outputs
//           and the RAM port
// All RAM-side outputs decode from registered state only. There is no path from any input
// to any output.
module mem_copy_engine #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 16
) (
  input logic              clk,
  input logic              reset,
  mem_copy_engine_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e            state;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  wordsDone;
  logic [DATA_W-1:0] hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
      wordsDone <= '0;
      hold      <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          // Start beats Abort here; Abort is meaningless outside a copy.
          if (bus.Start) begin
            src       <= bus.SrcAddr;
            dst       <= bus.DstAddr;
            remaining <= bus.Length;
            wordsDone <= '0;
            state     <= (bus.Length != '0) ? StRead : StDone;
          end
        end
        StRead: begin
          if (bus.Abort) begin
            state <= StIdle;
          end else begin
            // Capture only here, so a floating bus in other states never reaches WriteData.
            hold  <= bus.ReadData;
            state <= StWrite;
          end
        end
        StWrite: begin
          // The RAM commits the word on this edge even when Abort is high.
          src       <= src + ADDR_W'(1);
          dst       <= dst + ADDR_W'(1);
          wordsDone <= wordsDone + LEN_W'(1);
          remaining <= remaining - LEN_W'(1);
          if (bus.Abort) begin
            state <= StIdle;
          end else if (remaining == LEN_W'(1)) begin
            state <= StDone;
          end else begin
            state <= StRead;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  assign bus.Busy      = (state == StRead) || (state == StWrite);
  assign bus.Done      = (state == StDone);
  assign bus.ReadMem   = (state == StRead);
  assign bus.WriteMem  = (state == StWrite);
  assign bus.WriteData = hold;
  assign bus.WordsDone = wordsDone;

  always_comb begin
    bus.DataAddress = '0;
    unique case (state)
      StRead:  bus.DataAddress = src;
      StWrite: bus.DataAddress = dst;
      default: bus.DataAddress = '0;
    endcase
  end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Block-copy initiator for the 16-bit data RAM: on a Start pulse it reads Length words beginning at SrcAddr and writes them, in ascending order, to consecutive words beginning at DstAddr. It sits on the data-memory side of the datapath and drives the RAM's DataAddress/ReadMem/WriteMem/DataIn port. The RAM has an asynchronous read and a posedge-clk write. The engine needs no stall from the RAM and completes one word every two cycles.

## Interface
- ADDR_W, 16, address width (DataAddress, SrcAddr, DstAddr)
- DATA_W, 16, data word width
- LEN_W, 16, width of Length and WordsDone
- clk  in  1  single clock; every register updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- Start  in  1  request a copy; sampled only in IDLE
- Abort  in  1  stop the active copy; sampled in READ/WRITE
- SrcAddr  in  ADDR_W  first source word address; latched on accepted Start
- DstAddr  in  ADDR_W  first destination word address; latched on accepted Start
- Length  in  LEN_W  number of words to copy; latched on accepted Start
- Busy  out  1  high in READ and WRITE
- Done  out  1  one-cycle pulse in DONE state
- WordsDone  out  LEN_W  count of words written in current/last copy
- DataAddress  out  ADDR_W  RAM word address
- ReadMem  out  1  RAM read enable
- WriteMem  out  1  RAM write enable
- WriteData  out  DATA_W  to RAM DataIn
- ReadData  in  DATA_W  from RAM DataOut (combinational read; Z when ReadMem low)

## Operation
- States: IDLE, READ, WRITE, DONE. Registers: state, src, dst, remaining, WordsDone, hold (DATA_W).
- IDLE: all RAM strobes low, DataAddress=0. If Start=1 at posedge: latch SrcAddr/DstAddr/Length, clear WordsDone, go READ (Length≠0) or DONE (Length=0).
- READ: DataAddress=src, ReadMem=1, WriteMem=0. At posedge: hold<=ReadData, go WRITE.
- WRITE: DataAddress=dst, WriteMem=1, WriteData=hold, ReadMem=0. At posedge the RAM commits the word. src<=src+1, dst<=dst+1, WordsDone<=WordsDone+1, remaining<=remaining-1. Go DONE if remaining==1, else READ.
- DONE: Done=1, strobes low. Go IDLE unconditionally. Start in DONE is ignored.
- Abort=1 at posedge in READ: go IDLE, no write, no Done. Abort=1 at posedge in WRITE: the word in that cycle is still written (same edge), WordsDone increments, then go IDLE with no Done. Abort outside READ/WRITE is ignored. If Start and Abort are both high in IDLE, Start wins.
- Start while Busy is ignored; latched parameters are not disturbed.
- Address arithmetic is modulo 2^ADDR_W: 0xFFFF+1 wraps to 0x0000. Length is unsigned; Length=0xFFFF is legal.
- Copies are strictly ascending with no overlap protection. If dst lies in (src, src+Length), source words are overwritten before they are read; that result is the defined behaviour.
- hold is captured only in READ, so a Z bus in other states never reaches WriteData.
- ReadMem and WriteMem are never high in the same cycle.

## Timing
- Reset values: state=IDLE, Busy=0, Done=0, ReadMem=0, WriteMem=0, DataAddress=0, WriteData=0, WordsDone=0, hold=0.
- Strobes, DataAddress and WriteData decode from registered state and registers only, with no input-to-output combinational path.
- Start accepted at edge T0: READ during cycle T0+1, first WRITE during T0+2. The Nth word is written at the edge ending cycle T0+2N. Done is high during cycle T0+2·Length+1; IDLE follows at the next edge.
- Length=0: Done is high during cycle T0+1, with no RAM access.
- Back-to-back copies: the earliest next Start is accepted at the edge ending the IDLE cycle after DONE, giving 2·Length+2 cycles per copy.
- Reset asserted mid-copy: outputs clear asynchronously. A WRITE in progress at reset assertion is not guaranteed to land, and WordsDone reads 0.

## Test plan
- RAM preloaded mem[0x10..0x13]=A1,B2,C3,D4; Start with Src=0x10, Dst=0x40, Len=4 -> mem[0x40..0x43]=A1,B2,C3,D4; Done high exactly at cycle T0+9; WordsDone=4; ReadMem and WriteMem never both high.
- Len=0, Src=0x10, Dst=0x20 -> Done at T0+1; ReadMem and WriteMem never asserted; RAM unchanged.
- Src=0xFFFE, Dst=0x0100, Len=3 -> reads 0xFFFE, 0xFFFF, 0x0000 in order; writes 0x0100..0x0102.
- Len=8; Abort during the 3rd WRITE cycle -> 3 words written, 4th untouched, no Done pulse, WordsDone=3, IDLE next cycle. Repeat with Abort in the 3rd READ -> 2 words written.
- Start re-pulsed mid-copy with different parameters -> ignored; original copy completes unchanged. Reset asserted mid-copy -> Busy=0 and all strobes 0 in the same cycle, WordsDone=0.
- Overlap case, mem[0..3]=1,2,3,4; Src=0, Dst=1, Len=3 -> mem[0..3]=1,1,1,1.
